// File: rtl/sd_bus_arbiter.sv
// rtl/sd_bus_arbiter.sv - shares the SPI SD bus between the init engine and the read/write engines
module sd_bus_arbiter #(
   parameter int unsigned GAP_CYCLES    = 8,
   parameter int unsigned BUSY_WAIT_MAX = 15,
   parameter int unsigned RUN_TIMEOUT   = 65535
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sd_init_done,
   input  logic init_cs,
   input  logic init_mosi,
   input  logic rd_req,
   input  logic wr_req,
   output logic rd_start,
   output logic wr_start,
   input  logic rd_busy,
   input  logic wr_busy,
   input  logic rd_cs,
   input  logic rd_mosi,
   input  logic wr_cs,
   input  logic wr_mosi,
   output logic sd_cs,
   output logic sd_mosi,
   output logic grant_wr,
   output logic bus_busy,
   output logic err_timeout
);

   typedef enum logic [2:0] {
      ST_INIT,
      ST_ARB,
      ST_START,
      ST_WAIT_BUSY,
      ST_RUN,
      ST_GAP
   } state_t;

   localparam logic [16:0] GAP_LIM  = 17'(GAP_CYCLES);
   localparam logic [16:0] WAIT_LIM = 17'(BUSY_WAIT_MAX);
   localparam logic [16:0] RUN_LIM  = 17'(RUN_TIMEOUT);
   localparam bit          RUN_WDOG = (RUN_TIMEOUT != 0);

   state_t      state;
   logic [15:0] cnt;
   logic        last_wr;

   logic [16:0] cnt_inc;
   logic [15:0] cnt_sat;
   logic        granted_busy;
   logic        gap_done;
   logic        wait_expired;
   logic        run_expired;
   logic        arb_any;
   logic        arb_pick_wr;

   // Limits compare against the count this cycle would reach, so a state lasts exactly LIM clocks.
   assign cnt_inc      = {1'b0, cnt} + 17'd1;
   assign cnt_sat      = (&cnt) ? cnt : cnt_inc[15:0];
   assign granted_busy = grant_wr ? wr_busy : rd_busy;
   assign gap_done     = (cnt_inc >= GAP_LIM);
   assign wait_expired = (cnt_inc >= WAIT_LIM);
   assign run_expired  = RUN_WDOG && (cnt_inc >= RUN_LIM);
   assign arb_any      = rd_req | wr_req;
   assign arb_pick_wr  = wr_req & (~rd_req | ~last_wr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_INIT;
         cnt         <= 16'd0;
         last_wr     <= 1'b0;
         grant_wr    <= 1'b0;
         rd_start    <= 1'b0;
         wr_start    <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         rd_start    <= 1'b0;
         wr_start    <= 1'b0;
         err_timeout <= 1'b0;
         case (state)
            ST_INIT: begin
               if (sd_init_done) begin
                  state <= ST_GAP;
                  cnt   <= 16'd0;
               end
            end
            ST_ARB: begin
               if (arb_any) begin
                  grant_wr <= arb_pick_wr;
                  last_wr  <= arb_pick_wr;
                  rd_start <= ~arb_pick_wr;
                  wr_start <= arb_pick_wr;
                  state    <= ST_START;
                  cnt      <= 16'd0;
               end
            end
            ST_START: begin
               state <= ST_WAIT_BUSY;
               cnt   <= 16'd0;
            end
            ST_WAIT_BUSY: begin
               if (granted_busy) begin
                  state <= ST_RUN;
                  cnt   <= 16'd0;
               end else if (wait_expired) begin
                  err_timeout <= 1'b1;
                  state       <= ST_GAP;
                  cnt         <= 16'd0;
               end else begin
                  cnt <= cnt_sat;
               end
            end
            ST_RUN: begin
               if (!granted_busy) begin
                  state <= ST_GAP;
                  cnt   <= 16'd0;
               end else if (run_expired) begin
                  // The engine keeps running; only the bus is taken away from it.
                  err_timeout <= 1'b1;
                  state       <= ST_GAP;
                  cnt         <= 16'd0;
               end else begin
                  cnt <= cnt_sat;
               end
            end
            ST_GAP: begin
               if (gap_done) begin
                  state <= ST_ARB;
                  cnt   <= 16'd0;
               end else begin
                  cnt <= cnt_sat;
               end
            end
            default: begin
               state <= ST_INIT;
               cnt   <= 16'd0;
            end
         endcase
      end
   end

   // Reset forces the card idle at once, independent of the clock.
   always_comb begin
      sd_cs    = 1'b1;
      sd_mosi  = 1'b1;
      bus_busy = 1'b1;
      if (rst_n) begin
         bus_busy = (state != ST_ARB);
         case (state)
            ST_INIT: begin
               sd_cs   = init_cs;
               sd_mosi = init_mosi;
            end
            ST_START, ST_WAIT_BUSY, ST_RUN: begin
               sd_cs   = grant_wr ? wr_cs : rd_cs;
               sd_mosi = grant_wr ? wr_mosi : rd_mosi;
            end
            default: begin
               sd_cs   = 1'b1;
               sd_mosi = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_bus_arbiter.sv
// tb/tb_sd_bus_arbiter.sv - randomized bench for sd_bus_arbiter with a transaction-level reference model
module tb_sd_bus_arbiter;

   localparam int GAP = 8;
   localparam int BWM = 15;
   localparam int RT  = 50;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic sd_init_done, init_cs, init_mosi;
   logic rd_req, wr_req, rd_start, wr_start;
   logic rd_busy, wr_busy, rd_cs, rd_mosi, wr_cs, wr_mosi;
   logic sd_cs, sd_mosi, grant_wr, bus_busy, err_timeout;

   always #5 clk = ~clk;

   sd_bus_arbiter #(
      .GAP_CYCLES(GAP),
      .BUSY_WAIT_MAX(BWM),
      .RUN_TIMEOUT(RT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sd_init_done(sd_init_done),
      .init_cs(init_cs), .init_mosi(init_mosi),
      .rd_req(rd_req), .wr_req(wr_req), .rd_start(rd_start), .wr_start(wr_start),
      .rd_busy(rd_busy), .wr_busy(wr_busy),
      .rd_cs(rd_cs), .rd_mosi(rd_mosi), .wr_cs(wr_cs), .wr_mosi(wr_mosi),
      .sd_cs(sd_cs), .sd_mosi(sd_mosi), .grant_wr(grant_wr),
      .bus_busy(bus_busy), .err_timeout(err_timeout)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: who owns the bus, how long the idle gap still runs, timestamps of the current phase.
   bit m_init, m_fresh, m_seen, m_last_wr, m_err, m_ever;
   int m_gap, m_owner, m_since;

   int  rd_wait, rd_hold, wr_wait, wr_hold;
   int  rd_d, rd_l, wr_d, wr_l;
   bit  rand_mode, hold_reqs;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_init = 1; m_gap = 0; m_owner = -1; m_fresh = 0; m_seen = 0;
      m_since = 0; m_last_wr = 0; m_err = 0; m_ever = 0;
   endtask

   task automatic end_txn(input bit e);
      m_err   = e;
      m_owner = -1;
      m_gap   = GAP;
   endtask

   task automatic model_step();
      bit b;
      m_err = 0;
      if (!rst_n) begin
         model_reset();
      end else if (m_init) begin
         if (sd_init_done) begin
            m_init = 0;
            m_gap  = GAP;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else if (m_owner < 0) begin
         if (rd_req || wr_req) begin
            if (rd_req && wr_req) m_owner = m_last_wr ? 0 : 1;
            else                  m_owner = wr_req ? 1 : 0;
            m_last_wr = (m_owner == 1);
            m_fresh   = 1;
            m_ever    = 1;
         end
      end else if (m_fresh) begin
         m_fresh = 0;
         m_seen  = 0;
         m_since = 0;
      end else begin
         b = (m_owner == 1) ? wr_busy : rd_busy;
         m_since++;
         if (!m_seen) begin
            if (b) begin
               m_seen  = 1;
               m_since = 0;
            end else if (m_since >= BWM) begin
               end_txn(1);
            end
         end else if (!b) begin
            end_txn(0);
         end else if (RT != 0 && m_since >= RT) begin
            end_txn(1);
         end
      end
   endtask

   task automatic compare();
      logic e_cs, e_mosi, e_bb, e_rs, e_ws, e_err;
      if (!rst_n) begin
         e_cs = 1; e_mosi = 1; e_bb = 1; e_rs = 0; e_ws = 0; e_err = 0;
         check("grant_wr_rst", grant_wr, 0);
      end else begin
         e_bb  = m_init || (m_gap > 0) || (m_owner >= 0);
         e_rs  = (m_owner == 0) && m_fresh;
         e_ws  = (m_owner == 1) && m_fresh;
         e_err = m_err;
         if (m_init) begin
            e_cs = init_cs; e_mosi = init_mosi;
         end else if (m_owner == 0) begin
            e_cs = rd_cs; e_mosi = rd_mosi;
         end else if (m_owner == 1) begin
            e_cs = wr_cs; e_mosi = wr_mosi;
         end else begin
            e_cs = 1; e_mosi = 1;
         end
         if (m_owner >= 0)  check("grant_wr", grant_wr, (m_owner == 1));
         else if (!m_ever)  check("grant_wr_idle", grant_wr, 0);
      end
      check("sd_cs", sd_cs, e_cs);
      check("sd_mosi", sd_mosi, e_mosi);
      check("bus_busy", bus_busy, e_bb);
      check("rd_start", rd_start, e_rs);
      check("wr_start", wr_start, e_ws);
      check("err_timeout", err_timeout, e_err);
   endtask

   // Engine stand-ins: busy rises d cycles after the start cycle and stays high for l cycles.
   task automatic drive_engines();
      if (rand_mode) begin
         if (rd_start) begin rd_d = $urandom_range(0, 18); rd_l = $urandom_range(1, 60); end
         if (wr_start) begin wr_d = $urandom_range(0, 18); wr_l = $urandom_range(1, 60); end
      end
      if (rd_start) begin rd_wait = rd_d; rd_hold = rd_l; end
      if (wr_start) begin wr_wait = wr_d; wr_hold = wr_l; end
      if (rd_wait == 0 && rd_hold > 0) begin rd_busy = 1; rd_hold--; end
      else begin rd_busy = 0; if (rd_wait > 0) rd_wait--; end
      if (wr_wait == 0 && wr_hold > 0) begin wr_busy = 1; wr_hold--; end
      else begin wr_busy = 0; if (wr_wait > 0) wr_wait--; end
      rd_cs   = 1'($urandom_range(0, 1));
      rd_mosi = 1'($urandom_range(0, 1));
      wr_cs   = 1'($urandom_range(0, 1));
      wr_mosi = 1'($urandom_range(0, 1));
      if (!hold_reqs) begin
         if (rd_start) rd_req = 0;
         if (wr_start) wr_req = 0;
      end
      if (rand_mode) begin
         init_cs   = 1'($urandom_range(0, 1));
         init_mosi = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 99) == 0) sd_init_done = ~sd_init_done;
         if (!rd_req) rd_req = ($urandom_range(0, 9) == 0);
         else if ($urandom_range(0, 39) == 0) rd_req = 0;
         if (!wr_req) wr_req = ($urandom_range(0, 9) == 0);
         else if ($urandom_range(0, 39) == 0) wr_req = 0;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
      drive_engines();
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (bus_busy && n < max) begin cycle(); n++; end
      check("bus_returns_idle", bus_busy, 0);
   endtask

   task automatic wait_wr_start();
      int n = 0;
      while (!wr_start && n < 100) begin cycle(); n++; end
      check("wr_start_seen", wr_start, 1);
   endtask

   initial begin
      int n, n2, got, n_ws;
      bit seen_busy;
      int seq [4];

      sd_init_done = 0; init_cs = 1; init_mosi = 1;
      rd_req = 0; wr_req = 0; rd_busy = 0; wr_busy = 0;
      rd_cs = 1; rd_mosi = 1; wr_cs = 1; wr_mosi = 1;
      rd_wait = 0; rd_hold = 0; wr_wait = 0; wr_hold = 0;
      rd_d = 0; rd_l = 3; wr_d = 0; wr_l = 3;
      rand_mode = 0; hold_reqs = 0;
      model_reset();

      #2 rst_n = 0;
      #1;
      check("rst_sd_cs", sd_cs, 1);
      check("rst_sd_mosi", sd_mosi, 1);
      check("rst_bus_busy", bus_busy, 1);
      check("rst_starts", {rd_start, wr_start}, 2'b00);
      check("rst_grant_wr", grant_wr, 0);
      check("rst_err", err_timeout, 0);
      repeat (3) cycle();
      rst_n = 1;

      // init phase: the card sees the init engine until sd_init_done
      for (int i = 0; i < 12; i++) begin
         init_cs   = 1'(i % 2);
         init_mosi = 1'((i + 1) % 2);
         cycle();
         check("t1_cs_follows_init", sd_cs, (i % 2));
      end
      sd_init_done = 1;
      n = 0;
      do begin cycle(); n++; end while (bus_busy && n < 40);
      check("t1_init_gap_to_arb", n, GAP + 1);

      // both requesting: strict alternation, write first after reset
      hold_reqs = 1; rd_req = 1; wr_req = 1;
      got = 0; n = 0;
      while (got < 4 && n < 400) begin
         cycle(); n++;
         if (wr_start) begin seq[got] = 1; got++; end
         else if (rd_start) begin seq[got] = 0; got++; end
      end
      hold_reqs = 0; rd_req = 0; wr_req = 0;
      check("t3_grant_count", got, 4);
      for (int i = 0; i < 4; i++) check("t3_grant_order", seq[i], ((i % 2) == 0) ? 1 : 0);
      wait_idle(200);

      // single write, busy two clocks after start, then gap
      wr_d = 2; wr_l = 30; wr_req = 1;
      wait_wr_start();
      n_ws = 1; seen_busy = 0; n = 0;
      while (n < 200) begin
         cycle(); n++;
         if (wr_start) n_ws++;
         if (wr_busy) seen_busy = 1;
         if (seen_busy && !wr_busy) break;
      end
      check("t2_single_start", n_ws, 1);
      n2 = 0;
      do begin
         cycle(); n2++;
         if (n2 == 1) check("t2_cs_idle_after_fall", sd_cs, 1);
      end while (bus_busy && n2 < 50);
      check("t2_fall_to_arb", n2, GAP + 1);

      // busy never rises
      wr_d = 1000; wr_l = 5; wr_req = 1;
      wait_wr_start();
      n = 0;
      while (!err_timeout && n < 100) begin cycle(); n++; end
      check("t4_wait_timeout_latency", n, BWM + 1);
      wait_idle(50);

      // busy held past the run watchdog
      wr_d = 0; wr_l = 200; wr_req = 1;
      wait_wr_start();
      n = 0;
      while (!err_timeout && n < 200) begin cycle(); n++; end
      check("t5_run_timeout_latency", n, RT + 2);
      check("t5_cs_idle_on_timeout", sd_cs, 1);
      wait_idle(50);

      rand_mode = 1;
      repeat (3000) cycle();
      rand_mode = 0; rd_req = 0; wr_req = 0; sd_init_done = 1;
      wait_idle(300);

      // reset in the middle of a write
      wr_d = 0; wr_l = 200; wr_req = 1;
      wait_wr_start();
      repeat (5) cycle();
      check("t6_running_write", grant_wr, 1);
      @(posedge clk);
      model_step();
      #3 rst_n = 0;
      model_reset();
      #1;
      check("t6_async_cs_idle", sd_cs, 1);
      check("t6_async_grant_lost", grant_wr, 0);
      check("t6_async_bus_busy", bus_busy, 1);
      @(negedge clk);
      compare();
      drive_engines();
      cycle();
      sd_init_done = 0; init_cs = 0; init_mosi = 0;
      rst_n = 1;
      repeat (4) begin
         cycle();
         check("t6_back_in_init_cs", sd_cs, 0);
         check("t6_no_start_in_init", wr_start, 0);
      end
      wr_req = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
